// File: rtl/storage_pkg.sv
// Shared types and helpers for the cached storage controller: FSM states,
// address-region decode, byte-enable merge and response error codes.
package storage_pkg;

  typedef enum logic [2:0] {IDLE, SRAM_RD, SRAM_RMW, FL_REQ, FL_WAIT, RESP, PROG} state_e;
  typedef enum logic [1:0] {RGN_SRAM, RGN_FLASH, RGN_NONE} region_e;
  typedef enum logic [2:0] {ERR_NONE, ERR_ALIGN, ERR_DECODE, ERR_FLASH_WR, ERR_TIMEOUT} err_e;

  // Bounds are 33 bits so a region ending exactly at 4 GiB still decodes.
  function automatic region_e region_of(input logic [31:0] addr, input logic [32:0] sram_end,
                                        input logic [32:0] fl_base, input logic [32:0] fl_end);
    logic [32:0] a;
    a = {1'b0, addr};
    if (a < sram_end) return RGN_SRAM;
    if (a >= fl_base && a < fl_end) return RGN_FLASH;
    return RGN_NONE;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return w;
  endfunction

endpackage

// File: rtl/storage_read_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the flash engine.
// Combinational lookup, single-cycle fill, whole-cache flush of the valid bits.
module storage_read_cache #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic             fill,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             flush
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];

  assign hit      = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign hit_data = data[lk_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       valid <= '0;
    else if (flush) valid <= '0;
    else if (fill)  valid[fill_idx] <= 1'b1;
  end

  // Tag/data need no reset: they are never observed while the line is invalid.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/cached_storage_controller.sv
// Core data port bridge to an SRAM scratchpad (RMW byte writes) and read-only
// flash behind a read cache, with timeout/error responses and SPI programming passthrough.
module cached_storage_controller
  import storage_pkg::*;
#(
  parameter int          MEM_W          = 32,
  parameter int          SRAM_AW        = 11,
  parameter logic [31:0] FLASH_BASE     = 32'h0000_2000,
  parameter int          FLASH_AW       = 22,
  parameter int          CACHE_LINES    = 16,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_req,
  output logic                mem_gnt,
  input  logic                mem_we,
  input  logic [31:0]         mem_addr,
  input  logic [MEM_W/8-1:0]  mem_be,
  input  logic [MEM_W-1:0]    mem_wdata,
  output logic                mem_rvalid,
  output logic [MEM_W-1:0]    mem_rdata,
  output logic                mem_err,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [SRAM_AW-1:0]  sram_a,
  output logic [MEM_W-1:0]    sram_d,
  input  logic [MEM_W-1:0]    sram_q,
  output logic                fl_stb,
  output logic [FLASH_AW-1:0] fl_addr,
  input  logic                fl_stall,
  input  logic                fl_ack,
  input  logic [MEM_W-1:0]    fl_data,
  input  logic                prog_mode,
  input  logic                eng_cs_n,
  input  logic                eng_sck,
  input  logic                eng_mosi,
  output logic                eng_miso,
  input  logic                prg_cs_n,
  input  logic                prg_sck,
  input  logic                prg_mosi,
  output logic                prg_miso,
  output logic                ext_cs_n,
  output logic                ext_sck,
  output logic                ext_mosi,
  input  logic                ext_miso
);

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = FLASH_AW - IDX_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] SRAM_END = 33'd4 << SRAM_AW;
  localparam logic [32:0] FL_BASE  = {1'b0, FLASH_BASE};
  localparam logic [32:0] FL_END   = FL_BASE + (33'd4 << FLASH_AW);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e               state;
  err_e                 err_q, req_err;
  region_e              rgn;
  logic [31:0]          fl_off, resp_q, wdata_q;
  logic [3:0]           be_q;
  logic [SRAM_AW-1:0]   sram_idx_q;
  logic [FLASH_AW-1:0]  fl_word, fl_addr_q;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 hit;
  logic [31:0]          hit_data;

  assign rgn     = region_of(mem_addr, SRAM_END, FL_BASE, FL_END);
  assign fl_off  = mem_addr - FLASH_BASE;
  assign fl_word = FLASH_AW'(fl_off >> 2);
  assign mem_gnt = rst && mem_req && (state == IDLE) && !prog_mode;

  always_comb begin
    req_err = ERR_NONE;
    if (mem_addr[1:0] != 2'b00)          req_err = ERR_ALIGN;
    else if (rgn == RGN_NONE)            req_err = ERR_DECODE;
    else if (rgn == RGN_FLASH && mem_we) req_err = ERR_FLASH_WR;
  end

  storage_read_cache #(.LINES(CACHE_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_cache (
    .clk      (clk),
    .rst      (rst),
    .lk_idx   (fl_word[IDX_W-1:0]),
    .lk_tag   (fl_word[FLASH_AW-1:IDX_W]),
    .hit      (hit),
    .hit_data (hit_data),
    .fill     (state == FL_WAIT && fl_ack),
    .fill_idx (fl_addr_q[IDX_W-1:0]),
    .fill_tag (fl_addr_q[FLASH_AW-1:IDX_W]),
    .fill_data(fl_data),
    .flush    (state == PROG && !prog_mode)
  );

  // SRAM is driven straight from the request in the grant cycle so read data
  // lands on sram_q one cycle later; the RMW write half uses the latched request.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = sram_idx_q;
    sram_d   = mem_wdata;
    if (mem_gnt && req_err == ERR_NONE && rgn == RGN_SRAM) begin
      sram_a = SRAM_AW'(mem_addr >> 2);
      if (!mem_we) sram_cen = 1'b0;
      else if (mem_be == 4'hF) begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
      end else if (mem_be != 4'h0) sram_cen = 1'b0;
    end else if (state == SRAM_RMW) begin
      sram_cen = 1'b0;
      sram_wen = 1'b0;
      sram_d   = be_merge(sram_q, wdata_q, be_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      err_q      <= ERR_NONE;
      resp_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      sram_idx_q <= '0;
      fl_addr_q  <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (prog_mode) state <= PROG;
          else if (mem_req) begin
            err_q      <= req_err;
            resp_q     <= '0;
            wdata_q    <= mem_wdata;
            be_q       <= mem_be;
            sram_idx_q <= SRAM_AW'(mem_addr >> 2);
            fl_addr_q  <= fl_word;
            if (req_err != ERR_NONE) state <= RESP;
            else if (rgn == RGN_SRAM) begin
              if (!mem_we) state <= SRAM_RD;
              else if (mem_be == 4'hF || mem_be == 4'h0) state <= RESP;
              else state <= SRAM_RMW;
            end else if (hit) begin
              resp_q <= hit_data;
              state  <= RESP;
            end else state <= FL_REQ;
          end
        end
        SRAM_RD:  state <= IDLE;
        SRAM_RMW: state <= RESP;
        FL_REQ: if (!fl_stall) begin
          state   <= FL_WAIT;
          tmo_cnt <= '0;
        end
        FL_WAIT: begin
          if (fl_ack) begin
            resp_q <= fl_data;
            state  <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q <= ERR_TIMEOUT;
            state <= RESP;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        end
        RESP: state <= IDLE;
        PROG: if (!prog_mode) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rvalid = (state == SRAM_RD) || (state == RESP);
  assign mem_rdata  = (state == SRAM_RD) ? sram_q : (state == RESP) ? resp_q : '0;
  assign mem_err    = (state == RESP) && (err_q != ERR_NONE);
  assign fl_stb     = (state == FL_REQ);
  assign fl_addr    = fl_addr_q;

  always_comb begin
    if (state == PROG) begin
      {ext_cs_n, ext_sck, ext_mosi} = {prg_cs_n, prg_sck, prg_mosi};
      prg_miso = ext_miso;
      eng_miso = 1'b1;
    end else begin
      {ext_cs_n, ext_sck, ext_mosi} = {eng_cs_n, eng_sck, eng_mosi};
      eng_miso = ext_miso;
      prg_miso = 1'b0;
    end
  end

endmodule

// File: tb/tb_cached_storage_controller.sv
// Randomized bench for cached_storage_controller with SRAM macro and flash
// engine models plus a word-level reference of SRAM contents and cache state.
module tb_cached_storage_controller;

  localparam int TMO = 40;

  logic        clk = 0, rst = 0;
  logic        mem_req = 0, mem_we = 0, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic [3:0]  mem_be = 0;
  logic        sram_cen, sram_wen;
  logic [10:0] sram_a;
  logic [31:0] sram_d, sram_q;
  logic        fl_stb, fl_stall = 0, fl_ack = 0;
  logic [21:0] fl_addr;
  logic [31:0] fl_data = 0;
  logic        prog_mode = 0;
  logic        eng_cs_n = 1, eng_sck = 0, eng_mosi = 0, eng_miso;
  logic        prg_cs_n = 1, prg_sck = 0, prg_mosi = 0, prg_miso;
  logic        ext_cs_n, ext_sck, ext_mosi, ext_miso = 0;

  int vecs = 0, miss = 0;

  cached_storage_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .fl_stb(fl_stb), .fl_addr(fl_addr),
    .fl_stall(fl_stall), .fl_ack(fl_ack), .fl_data(fl_data), .prog_mode(prog_mode),
    .eng_cs_n(eng_cs_n), .eng_sck(eng_sck), .eng_mosi(eng_mosi), .eng_miso(eng_miso),
    .prg_cs_n(prg_cs_n), .prg_sck(prg_sck), .prg_mosi(prg_mosi), .prg_miso(prg_miso),
    .ext_cs_n(ext_cs_n), .ext_sck(ext_sck), .ext_mosi(ext_mosi), .ext_miso(ext_miso)
  );

  always #5 clk = ~clk;

  // SRAM macro: registered read data, one cycle after cen low.
  logic [31:0] sram_mem [2048];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) sram_mem[sram_a] <= sram_d;
      else           sram_q <= sram_mem[sram_a];
    end
  end

  // Flash engine: stalls a programmable number of cycles, acks after a delay.
  int stall_left = 0, ack_delay = 0, wait_cnt = 0, stb_cnt = 0;
  bit pending = 0, ack_en = 1;
  logic [21:0] pend_addr;

  function automatic logic [31:0] flash_word(input logic [21:0] w);
    return 32'hCAFE0001 + 32'(w) * 32'h0001_0003;
  endfunction

  always @(negedge clk) begin
    fl_ack = 0;
    if (fl_stb) stb_cnt++;
    if (pending) begin
      if (wait_cnt == 0) begin
        pending = 0;
        if (ack_en) begin
          fl_ack  = 1;
          fl_data = flash_word(pend_addr);
        end
      end else wait_cnt--;
    end else if (fl_stb) begin
      if (stall_left > 0) begin
        fl_stall = 1;
        stall_left--;
      end else begin
        fl_stall  = 0;
        pending   = 1;
        pend_addr = fl_addr;
        wait_cnt  = ack_delay;
      end
    end
  end

  // Reference state: SRAM words by word index, cache lines by index.
  logic [31:0] ref_sram [int];
  bit          ref_valid [16];
  int          ref_tag [16];

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    mem_req = 1; mem_we = we; mem_addr = addr; mem_be = be; mem_wdata = wd;
    #1;
    n = 0;
    while (!mem_gnt && n < 200) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    mem_req = 0;
    lat = -1; rd = 'x; er = 'x;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (mem_rvalid) begin
        lat = c; rd = mem_rdata; er = mem_err;
        break;
      end
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    eng_sck = 1; ext_miso = 1;
    #1;
    vecs++; if (mem_gnt !== 0 || mem_rvalid !== 0 || mem_err !== 0) begin miss++;
      $display("FAIL reset_hs got gnt=%b rv=%b err=%b want 0/0/0", mem_gnt, mem_rvalid, mem_err); end
    vecs++; if (mem_rdata !== 32'h0) begin miss++;
      $display("FAIL reset_rdata got %h want 0", mem_rdata); end
    vecs++; if (fl_stb !== 0 || sram_cen !== 1 || sram_wen !== 1) begin miss++;
      $display("FAIL reset_ctl got stb=%b cen=%b wen=%b want 0/1/1", fl_stb, sram_cen, sram_wen); end
    vecs++; if (ext_sck !== 1 || eng_miso !== 1 || prg_miso !== 0) begin miss++;
      $display("FAIL reset_spi got sck=%b emiso=%b pmiso=%b want 1/1/0", ext_sck, eng_miso, prg_miso); end
    eng_sck = 0; ext_miso = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_sram_basic();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 32'h40, 4'hF, 32'hDEADBEEF, rd, er, lat);
    vecs++; if (lat !== 1 || er !== 0 || rd !== 0) begin miss++;
      $display("FAIL sram_wr_full got lat=%0d err=%b rd=%h want 1/0/0", lat, er, rd); end
    do_req(0, 32'h40, 4'h0, 0, rd, er, lat);
    vecs++; if (lat !== 1 || rd !== 32'hDEADBEEF) begin miss++;
      $display("FAIL sram_rd got lat=%0d rd=%h want 1/deadbeef", lat, rd); end
    do_req(1, 32'h40, 4'b0011, 32'h00001122, rd, er, lat);
    vecs++; if (lat !== 2 || er !== 0) begin miss++;
      $display("FAIL sram_rmw_lat got lat=%0d err=%b want 2/0", lat, er); end
    do_req(0, 32'h40, 4'h0, 0, rd, er, lat);
    vecs++; if (rd !== 32'hDEAD1122) begin miss++;
      $display("FAIL sram_rmw_data got %h want dead1122", rd); end
    do_req(1, 32'h40, 4'h0, 32'h55555555, rd, er, lat);
    vecs++; if (lat !== 1 || er !== 0) begin miss++;
      $display("FAIL sram_be0_lat got lat=%0d err=%b want 1/0", lat, er); end
    do_req(0, 32'h40, 4'h0, 0, rd, er, lat);
    vecs++; if (rd !== 32'hDEAD1122) begin miss++;
      $display("FAIL sram_be0_data got %h want dead1122", rd); end
    ref_sram[16] = 32'hDEAD1122;
  endtask

  task automatic test_sram_random();
    logic [31:0] rd, wd, exp; logic er; logic [3:0] be; int lat, w, el; bit we;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_req(1, 32'h100 + 32'(4*i), 4'hF, wd, rd, er, lat);
      ref_sram[64+i] = wd;
    end
    for (int i = 0; i < 60; i++) begin
      w = 64 + $urandom_range(0, 15);
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      wd = $urandom;
      do_req(we, 32'(4*w), be, wd, rd, er, lat);
      if (we) begin
        ref_sram[w] = merge_ref(ref_sram[w], wd, be);
        exp = 0;
        el = (be == 4'hF || be == 4'h0) ? 1 : 2;
      end else begin
        exp = ref_sram[w];
        el = 1;
      end
      vecs++; if (rd !== exp || er !== 0 || lat !== el) begin miss++;
        $display("FAIL sram_rand we=%b be=%h got rd=%h err=%b lat=%0d want %h/0/%0d",
                 we, be, rd, er, lat, exp, el); end
    end
  endtask

  task automatic flash_read_check(input int w, input int stall, input int dly, input string nm);
    logic [31:0] rd; logic er; int lat, s0, idx, tag; bit exp_hit;
    idx = w % 16; tag = w / 16;
    exp_hit = ref_valid[idx] && ref_tag[idx] == tag;
    stall_left = stall; ack_delay = dly;
    s0 = stb_cnt;
    do_req(0, 32'h2000 + 32'(4*w), 4'h0, 0, rd, er, lat);
    vecs++; if (rd !== flash_word(22'(w)) || er !== 0) begin miss++;
      $display("FAIL %s w=%0d got rd=%h err=%b want %h/0", nm, w, rd, er, flash_word(22'(w))); end
    vecs++; if ((stb_cnt == s0) !== exp_hit || (exp_hit && lat != 1)) begin miss++;
      $display("FAIL %s_hit w=%0d got stb=%0d lat=%0d want hit=%b", nm, w, stb_cnt - s0, lat, exp_hit); end
    ref_valid[idx] = 1; ref_tag[idx] = tag;
  endtask

  task automatic test_flash();
    flash_read_check(0, 2, 1, "fl_first");
    flash_read_check(0, 0, 0, "fl_reread");
    for (int i = 0; i < 40; i++)
      flash_read_check($urandom_range(0, 63), $urandom_range(0, 2), $urandom_range(0, 3), "fl_rand");
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, s0;
    s0 = stb_cnt;
    do_req(1, 32'h2000, 4'hF, 32'h12345678, rd, er, lat);
    vecs++; if (er !== 1 || lat !== 1 || rd !== 0 || stb_cnt != s0) begin miss++;
      $display("FAIL err_flash_wr got err=%b lat=%0d rd=%h stb=%0d want 1/1/0/0", er, lat, rd, stb_cnt - s0); end
    do_req(0, 32'h1, 4'h0, 0, rd, er, lat);
    vecs++; if (er !== 1 || lat !== 1 || rd !== 0) begin miss++;
      $display("FAIL err_align got err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); end
    do_req(0, 32'h4000_0000, 4'h0, 0, rd, er, lat);
    vecs++; if (er !== 1 || lat !== 1 || rd !== 0) begin miss++;
      $display("FAIL err_decode got err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); end
    do_req(1, 32'h42, 4'hF, 32'h0, rd, er, lat);
    do_req(0, 32'h40, 4'h0, 0, rd, er, lat);
    vecs++; if (rd !== ref_sram[16]) begin miss++;
      $display("FAIL err_no_side got %h want %h", rd, ref_sram[16]); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er; int lat, w;
    w = 200;
    ack_en = 0; stall_left = 0; ack_delay = 0;
    do_req(0, 32'h2000 + 32'(4*w), 4'h0, 0, rd, er, lat);
    vecs++; if (er !== 1 || rd !== 0 || lat !== TMO + 2) begin miss++;
      $display("FAIL timeout got err=%b rd=%h lat=%0d want 1/0/%0d", er, rd, lat, TMO + 2); end
    ack_en = 1;
    flash_read_check(w, 0, 0, "fl_after_tmo");
  endtask

  task automatic test_prog();
    logic [31:0] rd; logic er; int lat;
    flash_read_check(0, 0, 0, "fl_pre_prog");
    @(negedge clk); prog_mode = 1;
    repeat (2) @(negedge clk);
    prg_sck = 1; eng_sck = 0; ext_miso = 1; mem_req = 1; mem_addr = 32'h40;
    #1;
    vecs++; if (ext_sck !== 1 || prg_miso !== 1 || eng_miso !== 1 || mem_gnt !== 0) begin miss++;
      $display("FAIL prog_mux1 got sck=%b pmiso=%b emiso=%b gnt=%b want 1/1/1/0",
               ext_sck, prg_miso, eng_miso, mem_gnt); end
    prg_sck = 0; eng_sck = 1; ext_miso = 0; mem_req = 0;
    #1;
    vecs++; if (ext_sck !== 0 || prg_miso !== 0 || eng_miso !== 1) begin miss++;
      $display("FAIL prog_mux0 got sck=%b pmiso=%b emiso=%b want 0/0/1", ext_sck, prg_miso, eng_miso); end
    @(negedge clk); prog_mode = 0;
    repeat (2) @(negedge clk);
    ext_miso = 1; #1;
    vecs++; if (ext_sck !== 1 || eng_miso !== 1 || prg_miso !== 0) begin miss++;
      $display("FAIL prog_exit_mux got sck=%b emiso=%b pmiso=%b want 1/1/0", ext_sck, eng_miso, prg_miso); end
    ext_miso = 0; eng_sck = 0;
    for (int i = 0; i < 16; i++) ref_valid[i] = 0;
    flash_read_check(0, 1, 1, "fl_post_prog");
    do_req(0, 32'h40, 4'h0, 0, rd, er, lat);
    vecs++; if (rd !== ref_sram[16] || lat !== 1) begin miss++;
      $display("FAIL post_prog_sram got rd=%h lat=%0d want %h/1", rd, lat, ref_sram[16]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin ref_valid[i] = 0; ref_tag[i] = 0; end
    test_reset();
    test_sram_basic();
    test_sram_random();
    test_flash();
    test_errors();
    test_timeout();
    test_prog();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
